// File: rtl/glb_pkg.sv
// Shared GLB constants and word type, reused by token_engine for GLB address generation.
package glb_pkg;
    localparam int GLB_DATA_W = 32;
    localparam int GLB_DEPTH  = 16384;
    localparam int GLB_ADDR_W = 14;
    localparam int GLB_BYTES  = GLB_DATA_W / 8;

    typedef logic [GLB_DATA_W-1:0] glb_word_t;
endpackage

// File: rtl/glb_sram_64kb.sv
// 64 KB single-port GLB SRAM model with active-low byte write enables and a registered read port.
// Define GLB_RDW_FWD_EN to return the merged new word on a same-index read-during-write (else read-first).
module glb_sram_64kb
    import glb_pkg::*;
#(
    parameter int DATA_W = GLB_DATA_W,
    parameter int DEPTH  = GLB_DEPTH,
    parameter int ADDR_W = GLB_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W/8-1:0] WEB,
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   write_data,
    output logic [DATA_W-1:0]   read_data
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] memory [0:DEPTH-1];

    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] wr_word;
    logic              any_we;
    logic              unused_addr_hi;

    // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH.
    assign idx            = addr[ADDR_W-1:0];
    assign unused_addr_hi = ^addr[31:ADDR_W];
    assign cur_word       = memory[idx];
    assign any_we         = (WEB != {NB{1'b1}});

    // Merged word: written lanes take new bytes, the rest keep the stored bytes.
    for (genvar b = 0; b < NB; b++) begin : g_lane
        assign wr_word[8*b +: 8] = WEB[b] ? cur_word[8*b +: 8] : write_data[8*b +: 8];
    end

    // Storage is never reset so preloaded contents survive; writes are blocked while reset is high.
    always_ff @(posedge clk) begin
        if (!rst_n && any_we) begin
            memory[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            read_data <= '0;
        end else begin
`ifdef GLB_RDW_FWD_EN
            read_data <= wr_word;
`else
            read_data <= cur_word;
`endif
        end
    end
endmodule

// File: tb/tb_glb_sram_64kb.sv
// Scoreboard bench for glb_sram_64kb: driver pushes model predictions, monitor pops one per edge.
module tb_glb_sram_64kb;
    import glb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  WEB = 4'hF;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    glb_sram_64kb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .WEB        (WEB),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    function automatic void check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    endfunction

    // Reference: a sparse word store; only words the bench has fully defined are checked.
    task automatic access(input logic [3:0] web, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int          idx;
        bit          known;
        logic [31:0] old_w;
        logic [31:0] new_w;
        exp_t        e;
        @(negedge clk);
        WEB = web; addr = a; write_data = d;
        idx   = int'(a % 32'd16384);
        known = ref_mem.exists(idx);
        old_w = known ? ref_mem[idx] : 32'h0;
        new_w = old_w;
        for (int b = 0; b < 4; b++)
            if (!web[b]) new_w[8*b +: 8] = d[8*b +: 8];
`ifdef GLB_RDW_FWD_EN
        e.exp = new_w;
        e.chk = known || (web == 4'h0);
`else
        e.exp = old_w;
        e.chk = known;
`endif
        e.tag = tag;
        sb.push_back(e);
        if (web != 4'hF) begin
            if (known || web == 4'h0) ref_mem[idx] = new_w;
            else ref_mem.delete(idx);
        end
        @(posedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                if (mon_e.chk) check(mon_e.tag, read_data, mon_e.exp);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 check("reset_state", read_data, 32'h0);
        rst_n = 1'b0;

        // Preload and reset behaviour
        access(4'h0, 32'd5, 32'h0BADF00D, "pre5");
        access(4'h0, 32'd7, 32'hFFFFFFFF, "pre7");
        access(4'hF, 32'd7, 32'h0, "rd7");
        @(negedge clk);
        #1 check("pre_rst", read_data, 32'hFFFFFFFF);
        rst_n = 1'b1;
        #1 check("rst_async", read_data, 32'h0);
        WEB = 4'h0; addr = 32'd5; write_data = 32'h12345678;
        @(posedge clk);
        #1 check("rst_hold", read_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b0; WEB = 4'hF;
        check("mem5_kept", dut.memory[5], 32'h0BADF00D);
        access(4'hF, 32'd5, 32'h0, "rd5_post_rst");

        // Full word write then read
        access(4'h0, 32'h3000, 32'hDEADBEEF, "wr_full");
        access(4'hF, 32'h3000, 32'h0, "rd_full");
        #1 check("mem_12288", dut.memory[12288], 32'hDEADBEEF);

        // Byte lanes
        access(4'h0, 32'h40, 32'h11223344, "byte_pre");
        access(4'b1110, 32'h40, 32'h000000AA, "byte0_wr");
        access(4'hF, 32'h40, 32'h0, "byte0_rd");
        #1 check("byte0_mem", dut.memory[32'h40], 32'h112233AA);
        access(4'b0111, 32'h40, 32'h99000000, "byte3_wr");
        access(4'hF, 32'h40, 32'h0, "byte3_rd");
        #1 check("byte3_mem", dut.memory[32'h40], 32'h992233AA);

        // Address wrap
        access(4'h0, 32'h0001_3000, 32'hCAFEF00D, "wrap_wr");
        access(4'hF, 32'h3000, 32'h0, "wrap_rd");
        #1 check("wrap_mem", dut.memory[32'h3000], 32'hCAFEF00D);

        // Read-during-write, same index
        access(4'h0, 32'h50, 32'h11, "rdw_pre");
        access(4'h0, 32'h50, 32'h55, "rdw");
        access(4'hF, 32'h50, 32'h0, "rdw_after");

        // Streaming
        for (int i = 0; i < 640; i++) access(4'h0, 32'h3000 + i, i, "stream_wr");
        for (int i = 0; i < 640; i++) access(4'hF, 32'h3000 + i, 32'h0, "stream_rd");

        // Randomised mix on a small window, with random upper address bits
        for (int i = 0; i < 16; i++) access(4'h0, 32'h100 + i, $urandom, "rnd_pre");
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            logic [3:0]  rw;
            ra = {$urandom_range(0, 65535), 16'h0} | (32'h100 + $urandom_range(0, 15));
            ra[15:14] = 2'($urandom_range(0, 3));
            rw = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            access(rw, ra, $urandom, "rnd");
        end

        @(negedge clk);
        WEB = 4'hF;
        repeat (2) @(negedge clk);
        n_tot++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
